// File: rtl/hpdcache_mshr_ctrl_pkg.sv
// Shared types for the MSHR sequencer: FSM state encoding and the allocation payload
// carried from the miss handler into the MSHR.
package hpdcache_pkg;

  localparam int NLINE_W    = 8;
  localparam int MSHR_SET_W = 3;
  localparam int MSHR_WAY_W = 2;
  localparam int MSHR_WAYS  = 4;
  localparam int TAG_W      = NLINE_W - MSHR_SET_W;

  typedef enum logic {
    IDLE = 1'b0,
    CHK1 = 1'b1
  } hpdcache_mshr_ctrl_state_e;

  typedef struct packed {
    logic [3:0] req_id;
    logic [1:0] src_id;
    logic [2:0] word;
    logic [1:0] victim_way;
    logic       need_rsp;
    logic       is_prefetch;
    logic       wback;
  } hpdcache_mshr_alloc_meta_t;

  localparam int META_W = $bits(hpdcache_mshr_alloc_meta_t);

endpackage

// File: rtl/hpdcache_mshr_ctrl.sv
// Arbitrates the single-port MSHR between miss-pipeline check/alloc sequences and
// refill acks, issuing at most one MSHR command per cycle.
module hpdcache_mshr_ctrl
  import hpdcache_pkg::*;
#(
  parameter int unsigned MaxAckBurst = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  chk_valid_i,
  output logic                  chk_ready_o,
  input  logic [NLINE_W-1:0]    chk_nline_i,
  input  logic                  chk_alloc_i,
  input  logic [META_W-1:0]     chk_meta_i,
  output logic                  chk_rsp_valid_o,
  output logic                  chk_rsp_hit_o,
  output logic                  chk_rsp_full_o,
  output logic                  chk_rsp_alloc_o,
  output logic [MSHR_WAY_W-1:0] chk_rsp_way_o,

  input  logic                  ack_valid_i,
  output logic                  ack_ready_o,
  input  logic [MSHR_SET_W-1:0] ack_set_i,
  input  logic [MSHR_WAY_W-1:0] ack_way_i,
  output logic                  ack_rsp_valid_o,

  output logic                  mshr_check_o,
  output logic                  mshr_check_cs_o,
  output logic [MSHR_SET_W-1:0] mshr_check_set_o,
  output logic [TAG_W-1:0]      mshr_check_tag_o,
  output logic                  mshr_alloc_o,
  output logic                  mshr_alloc_cs_o,
  output logic [NLINE_W-1:0]    mshr_alloc_nline_o,
  output logic [META_W-1:0]     mshr_alloc_meta_o,
  output logic                  mshr_ack_o,
  output logic                  mshr_ack_cs_o,
  output logic [MSHR_SET_W-1:0] mshr_ack_set_o,
  output logic [MSHR_WAY_W-1:0] mshr_ack_way_o,
  input  logic                  mshr_hit_i,
  input  logic                  mshr_alloc_full_i,
  input  logic [MSHR_WAY_W-1:0] mshr_alloc_way_i
);

  localparam logic [3:0] BURST_MAX = 4'(MaxAckBurst);

  hpdcache_mshr_ctrl_state_e state_q;
  logic [3:0]                burst_q, burst_d;
  logic [NLINE_W-1:0]        nline_q;
  logic [META_W-1:0]         meta_q;
  logic                      alloc_q;
  logic                      ack_rsp_q;

  logic in_idle, in_chk1, chk_grant, ack_grant, do_alloc;

  // A waiting check is forced through once the ack streak reaches the limit.
  assign in_idle   = (state_q == IDLE);
  assign in_chk1   = (state_q == CHK1);
  assign chk_grant = in_idle & chk_valid_i & (~ack_valid_i | (burst_q == BURST_MAX));
  assign ack_grant = in_idle & ack_valid_i & ~chk_grant;
  assign do_alloc  = in_chk1 & alloc_q & ~mshr_hit_i & ~mshr_alloc_full_i;

  assign burst_d = (chk_valid_i && burst_q != BURST_MAX) ? burst_q + 4'd1 : burst_q;

  assign chk_ready_o      = chk_grant;
  assign ack_ready_o      = ack_grant;
  assign chk_rsp_valid_o  = in_chk1;
  assign chk_rsp_hit_o    = in_chk1 & mshr_hit_i;
  assign chk_rsp_full_o   = in_chk1 & mshr_alloc_full_i & ~mshr_hit_i;
  assign chk_rsp_alloc_o  = do_alloc;
  assign chk_rsp_way_o    = do_alloc ? mshr_alloc_way_i : '0;
  assign ack_rsp_valid_o  = ack_rsp_q;

  assign mshr_check_o       = chk_grant;
  assign mshr_check_cs_o    = chk_grant;
  assign mshr_check_set_o   = chk_nline_i[MSHR_SET_W-1:0];
  assign mshr_check_tag_o   = chk_nline_i[NLINE_W-1:MSHR_SET_W];
  assign mshr_alloc_o       = do_alloc;
  assign mshr_alloc_cs_o    = do_alloc;
  assign mshr_alloc_nline_o = nline_q;
  assign mshr_alloc_meta_o  = meta_q;
  assign mshr_ack_o         = ack_grant;
  assign mshr_ack_cs_o      = ack_grant;
  assign mshr_ack_set_o     = ack_set_i;
  assign mshr_ack_way_o     = ack_way_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      burst_q   <= '0;
      nline_q   <= '0;
      meta_q    <= '0;
      alloc_q   <= 1'b0;
      ack_rsp_q <= 1'b0;
    end else begin
      ack_rsp_q <= ack_grant;
      case (state_q)
        IDLE: begin
          if (chk_grant) begin
            state_q <= CHK1;
            nline_q <= chk_nline_i;
            meta_q  <= chk_meta_i;
            alloc_q <= chk_alloc_i;
          end else if (ack_grant) begin
            burst_q <= burst_d;
          end
        end
        CHK1: begin
          state_q <= IDLE;
          burst_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  a_one_cmd: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(mshr_ack_o && (mshr_check_o || mshr_alloc_o)));
  a_alloc_clean: assert property (@(posedge clk_i) disable iff (!rst_ni)
    chk_rsp_alloc_o |-> (!chk_rsp_hit_o && !chk_rsp_full_o));

endmodule

// File: tb/tb_hpdcache_mshr_ctrl.sv
// Bench for the MSHR sequencer: a small MSHR behavioural model closes the loop, and a
// scoreboard-level reference predicts grants and check results.
module tb_hpdcache_mshr_ctrl;
  import hpdcache_pkg::*;

  localparam int MAXB = 4;

  typedef struct { logic cv; logic [7:0] nl; logic al; logic av; logic [2:0] as; logic [1:0] aw; } stim_t;
  typedef struct { logic cr, ar, rv, hit, full, al; logic [1:0] way; logic arv; } exp_t;
  typedef struct { stim_t s; exp_t e; } vec_t;

  logic clk = 1'b0, rst_ni = 1'b0;
  logic chk_valid_i = 0, chk_alloc_i = 0, ack_valid_i = 0;
  logic [7:0] chk_nline_i = '0;
  logic [13:0] chk_meta_i = '0;
  logic [2:0] ack_set_i = '0;
  logic [1:0] ack_way_i = '0;
  logic chk_ready_o, chk_rsp_valid_o, chk_rsp_hit_o, chk_rsp_full_o, chk_rsp_alloc_o;
  logic [1:0] chk_rsp_way_o;
  logic ack_ready_o, ack_rsp_valid_o;
  logic mshr_check_o, mshr_check_cs_o, mshr_alloc_o, mshr_alloc_cs_o, mshr_ack_o, mshr_ack_cs_o;
  logic [2:0] mshr_check_set_o, mshr_ack_set_o;
  logic [4:0] mshr_check_tag_o;
  logic [7:0] mshr_alloc_nline_o;
  logic [13:0] mshr_alloc_meta_o;
  logic [1:0] mshr_ack_way_o;
  logic m_hit, m_full;
  logic [1:0] m_way;

  always #5 clk = ~clk;

  hpdcache_mshr_ctrl #(.MaxAckBurst(MAXB)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .chk_valid_i(chk_valid_i), .chk_ready_o(chk_ready_o), .chk_nline_i(chk_nline_i),
    .chk_alloc_i(chk_alloc_i), .chk_meta_i(chk_meta_i),
    .chk_rsp_valid_o(chk_rsp_valid_o), .chk_rsp_hit_o(chk_rsp_hit_o), .chk_rsp_full_o(chk_rsp_full_o),
    .chk_rsp_alloc_o(chk_rsp_alloc_o), .chk_rsp_way_o(chk_rsp_way_o),
    .ack_valid_i(ack_valid_i), .ack_ready_o(ack_ready_o), .ack_set_i(ack_set_i), .ack_way_i(ack_way_i),
    .ack_rsp_valid_o(ack_rsp_valid_o),
    .mshr_check_o(mshr_check_o), .mshr_check_cs_o(mshr_check_cs_o), .mshr_check_set_o(mshr_check_set_o),
    .mshr_check_tag_o(mshr_check_tag_o), .mshr_alloc_o(mshr_alloc_o), .mshr_alloc_cs_o(mshr_alloc_cs_o),
    .mshr_alloc_nline_o(mshr_alloc_nline_o), .mshr_alloc_meta_o(mshr_alloc_meta_o),
    .mshr_ack_o(mshr_ack_o), .mshr_ack_cs_o(mshr_ack_cs_o), .mshr_ack_set_o(mshr_ack_set_o),
    .mshr_ack_way_o(mshr_ack_way_o),
    .mshr_hit_i(m_hit), .mshr_alloc_full_i(m_full), .mshr_alloc_way_i(m_way)
  );

  // ---------------- MSHR behavioural model (environment) ----------------
  bit          m_v    [8][4];
  logic [7:0]  m_nl   [8][4];
  logic [13:0] m_meta [8][4];
  logic [7:0]  m_ack_nl;
  logic [13:0] m_ack_meta;
  logic        m_clr = 1'b1;

  function automatic bit m_match(input logic [2:0] st, input logic [7:0] nl);
    for (int w = 0; w < 4; w++) if (m_v[st][w] && m_nl[st][w] == nl) return 1'b1;
    return 1'b0;
  endfunction
  function automatic int m_used(input logic [2:0] st);
    int c = 0;
    for (int w = 0; w < 4; w++) if (m_v[st][w]) c++;
    return c;
  endfunction
  function automatic logic [1:0] m_free(input logic [2:0] st);
    for (int w = 0; w < 4; w++) if (!m_v[st][w]) return 2'(w);
    return 2'd0;
  endfunction
  function automatic int m_total();
    int c = 0;
    for (int s = 0; s < 8; s++) c += m_used(3'(s));
    return c;
  endfunction

  always @(posedge clk) begin
    if (m_clr) begin
      for (int s = 0; s < 8; s++)
        for (int w = 0; w < 4; w++) begin
          m_v[s][w] <= 1'b0; m_nl[s][w] <= '0; m_meta[s][w] <= '0;
        end
      m_hit <= 1'b0; m_full <= 1'b0; m_way <= '0; m_ack_nl <= '0; m_ack_meta <= '0;
    end else begin
      if (mshr_check_o) begin
        m_hit  <= m_match(mshr_check_set_o, {mshr_check_tag_o, mshr_check_set_o});
        m_full <= (m_used(mshr_check_set_o) == 4);
        m_way  <= m_free(mshr_check_set_o);
      end
      if (mshr_alloc_o) begin
        m_v[mshr_alloc_nline_o[2:0]][m_way]    <= 1'b1;
        m_nl[mshr_alloc_nline_o[2:0]][m_way]   <= mshr_alloc_nline_o;
        m_meta[mshr_alloc_nline_o[2:0]][m_way] <= mshr_alloc_meta_o;
      end
      if (mshr_ack_o) begin
        m_ack_nl   <= m_nl[mshr_ack_set_o][mshr_ack_way_o];
        m_ack_meta <= m_meta[mshr_ack_set_o][mshr_ack_way_o];
        m_v[mshr_ack_set_o][mshr_ack_way_o] <= 1'b0;
      end
    end
  end

  // ---------------- reference model (scoreboard level) ----------------
  bit         sb_v  [8][4];
  logic [7:0] sb_nl [8][4];
  bit busy, pend_al, ack_prev;
  int streak;
  logic [7:0] pend_nl, ack_exp_nl;
  int nerr = 0, nchk = 0;

  function automatic logic [13:0] meta_of(input logic [7:0] nl);
    return {nl[5:0], nl};
  endfunction

  task automatic ref_clear();
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 4; w++) begin sb_v[s][w] = 0; sb_nl[s][w] = '0; end
    busy = 0; pend_al = 0; ack_prev = 0; streak = 0; pend_nl = '0; ack_exp_nl = '0;
  endtask

  function automatic exp_t predict(input stim_t s);
    exp_t e = '{default: 1'b0, way: 2'd0};
    int cnt = 0, fw = -1;
    bit hit = 0;
    e.arv = ack_prev;
    if (busy) begin
      for (int w = 0; w < 4; w++) begin
        if (sb_v[pend_nl[2:0]][w]) begin
          cnt++;
          if (sb_nl[pend_nl[2:0]][w] == pend_nl) hit = 1;
        end else if (fw < 0) fw = w;
      end
      e.rv = 1; e.hit = hit; e.full = (cnt == 4) && !hit;
      e.al = pend_al && !hit && (cnt < 4);
      e.way = e.al ? 2'(fw) : 2'd0;
    end else begin
      e.cr = s.cv && (!s.av || streak == MAXB);
      e.ar = s.av && !e.cr;
    end
    return e;
  endfunction

  task automatic ref_update(input stim_t s, input exp_t e);
    if (busy) begin
      if (e.al) begin sb_v[pend_nl[2:0]][e.way] = 1; sb_nl[pend_nl[2:0]][e.way] = pend_nl; end
      busy = 0; streak = 0;
    end else if (e.cr) begin
      busy = 1; pend_nl = s.nl; pend_al = s.al;
    end else if (e.ar) begin
      ack_exp_nl = sb_nl[s.as][s.aw];
      sb_v[s.as][s.aw] = 0;
      if (s.cv && streak < MAXB) streak++;
    end
    ack_prev = e.ar;
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input stim_t s);
    chk_valid_i = s.cv; chk_nline_i = s.nl; chk_alloc_i = s.al; chk_meta_i = meta_of(s.nl);
    ack_valid_i = s.av; ack_set_i = s.as; ack_way_i = s.aw;
  endtask

  // One clock: drive at negedge, compare just after, advance the reference.
  task automatic cyc(input stim_t s, input exp_t te, input bit use_tbl);
    exp_t p, e;
    @(negedge clk);
    drive(s);
    p = predict(s);
    e = use_tbl ? te : p;
    #1;
    cmp("chk_ready", 32'(chk_ready_o), 32'(e.cr));
    cmp("ack_ready", 32'(ack_ready_o), 32'(e.ar));
    cmp("mshr_check", 32'(mshr_check_o), 32'(e.cr));
    cmp("mshr_ack", 32'(mshr_ack_o), 32'(e.ar));
    cmp("rsp_valid", 32'(chk_rsp_valid_o), 32'(e.rv));
    cmp("rsp_hit", 32'(chk_rsp_hit_o), 32'(e.hit));
    cmp("rsp_full", 32'(chk_rsp_full_o), 32'(e.full));
    cmp("rsp_alloc", 32'(chk_rsp_alloc_o), 32'(e.al));
    cmp("mshr_alloc", 32'(mshr_alloc_o), 32'(e.al));
    cmp("rsp_way", 32'(chk_rsp_way_o), 32'(e.way));
    cmp("ack_rsp_valid", 32'(ack_rsp_valid_o), 32'(e.arv));
    if (e.arv) begin
      cmp("ack_nline", 32'(m_ack_nl), 32'(ack_exp_nl));
      cmp("ack_meta", 32'(m_ack_meta), 32'(meta_of(ack_exp_nl)));
    end
    ref_update(s, p);
  endtask

  task automatic do_reset();
    stim_t z = '{default: '0};
    @(negedge clk);
    drive(z);
    rst_ni = 1'b0; m_clr = 1'b1;
    ref_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1; m_clr = 1'b0;
  endtask

  function automatic vec_t mk(input logic cv, input logic [7:0] nl, input logic al, input logic av,
                              input logic [2:0] as, input logic [1:0] aw,
                              input logic cr, input logic ar, input logic rv, input logic hit,
                              input logic full, input logic alc, input logic [1:0] way, input logic arv);
    vec_t v;
    v.s = '{cv: cv, nl: nl, al: al, av: av, as: as, aw: aw};
    v.e = '{cr: cr, ar: ar, rv: rv, hit: hit, full: full, al: alc, way: way, arv: arv};
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t  tbl [$];
    stim_t s;
    exp_t  ez = '{default: 1'b0, way: 2'd0};

    //            cv nline al av as aw   cr ar rv hit full al way arv
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h40, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0,  0, 0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h40, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h03, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0,  0, 0, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h0B, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0,  0, 0, 1, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 8'h13, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0,  0, 0, 1, 0, 0, 1, 2, 0));
    tbl.push_back(mk(1, 8'h1B, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0,  0, 0, 1, 0, 0, 1, 3, 0));
    tbl.push_back(mk(1, 8'h23, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 3, 1,  0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h0B, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 1, 3, 2,  0, 0, 1, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 3, 2,  0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h13, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h2B, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0,  0, 0, 1, 0, 0, 1, 2, 0));
    tbl.push_back(mk(1, 8'h0B, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h40, 0, 1, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h40, 0, 1, 0, 0,  0, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 8'h40, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 0));

    do_reset();
    foreach (tbl[i]) cyc(tbl[i].s, tbl[i].e, 1'b1);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      s.cv = 1'($urandom_range(0, 1));
      s.nl = 8'(($urandom_range(0, 5) << 3) | $urandom_range(0, 1));
      s.al = 1'($urandom_range(0, 3) != 0);
      s.av = 1'($urandom_range(0, 2) == 0);
      s.as = 3'($urandom_range(0, 1));
      s.aw = 2'($urandom_range(0, 3));
      cyc(s, ez, 1'b0);
    end

    // Both requesters held: four acks, one forced check, one response cycle, repeating.
    do_reset();
    s = '{cv: 1'b1, nl: 8'h05, al: 1'b0, av: 1'b1, as: 3'd5, aw: 2'd0};
    for (int i = 0; i < 24; i++) begin
      cyc(s, ez, 1'b0);
      cmp("burst_ack", 32'(ack_ready_o), 32'((i % 6) < 4));
      cmp("burst_chk", 32'(chk_ready_o), 32'((i % 6) == 4));
    end

    // Reset asserted while the alloc is about to be issued.
    do_reset();
    s = '{cv: 1'b1, nl: 8'h11, al: 1'b1, av: 1'b0, as: 3'd0, aw: 2'd0};
    cyc(s, ez, 1'b0);
    @(negedge clk);
    s = '{default: '0};
    drive(s);
    #1;
    cmp("pre_rst_rsp_valid", 32'(chk_rsp_valid_o), 32'd1);
    cmp("pre_rst_alloc", 32'(mshr_alloc_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    cmp("rst_alloc", 32'(mshr_alloc_o), 32'd0);
    cmp("rst_rsp_valid", 32'(chk_rsp_valid_o), 32'd0);
    cmp("rst_rsp_alloc", 32'(chk_rsp_alloc_o), 32'd0);
    cmp("rst_ack_rsp", 32'(ack_rsp_valid_o), 32'd0);
    cmp("rst_check", 32'(mshr_check_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    ref_clear();
    cmp("mshr_empty", 32'(m_total()), 32'd0);
    cyc(s, ez, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
